// File: rtl/sim_intf_pkg.sv
// Shared types and default widths for the buffered sim interface.
// The entry struct describes the (pc, insn) pair held in the reference FIFO.
package sim_intf_pkg;

    localparam int XLEN_DEF = 64;
    localparam int ILEN_DEF = 32;

    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [ILEN_DEF-1:0] insn;
    } ref_entry_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fq_state_t;

endpackage

// File: rtl/sim_intf_ref_fifo.sv
// Circular buffer of reference entries; pointers carry an extra wrap bit
// so full and empty are distinguishable without a separate counter.
module sim_intf_ref_fifo #(
    parameter int W     = 96,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    // Storage is not reset: the pointers alone define which slots are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sim_intf_fq.sv
// Compares core fetch PCs against the head of a queued reference stream,
// returns the instruction on a match and halts after a run of misses.
module sim_intf_fq
    import sim_intf_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int ILEN       = ILEN_DEF,
    parameter int DEPTH      = 4,
    parameter int MISS_LIMIT = 8,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [XLEN-1:0]  req_pc,
    input  logic             ref_valid,
    output logic             ref_ready,
    input  logic [XLEN-1:0]  ref_pc,
    input  logic [ILEN-1:0]  ref_insn,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  resp_pc_try,
    output logic [XLEN-1:0]  resp_pc_factual,
    output logic [ILEN-1:0]  resp_insn,
    output logic             resp_miss,
    output logic             halted,
    output logic [CNT_W-1:0] miss_count,
    input  logic             clear
);

    localparam int EW     = XLEN + ILEN;
    localparam int CONS_W = (MISS_LIMIT > 0) ? $clog2(MISS_LIMIT + 1) : 1;
    localparam logic [CONS_W-1:0] LIMIT_V = CONS_W'(MISS_LIMIT);

    // Handshakes: a transfer happens on a rising edge where valid & ready are
    // both high; ready never depends on valid of the same channel.

    logic [EW-1:0]     head;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              accept;
    logic              is_miss;
    logic [XLEN-1:0]   head_pc;
    logic [ILEN-1:0]   head_insn;
    logic [CONS_W-1:0] consec;
    logic [CONS_W-1:0] cons_inc;
    fq_state_t         state;

    assign head_pc   = head[EW-1:ILEN];
    assign head_insn = head[ILEN-1:0];

    assign ref_ready = !full;
    assign push      = ref_valid && !full;
    assign req_ready = (state == ST_RUN) && !empty && !clear && (!resp_valid || resp_ready);
    assign accept    = req_valid && req_ready;
    assign is_miss   = (req_pc != head_pc);
    assign pop       = accept && !is_miss;
    assign cons_inc  = consec + 1'b1;
    assign halted    = (state == ST_HALT);

    sim_intf_ref_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   ({ref_pc, ref_insn}),
        .pop   (pop),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_RUN;
            consec          <= '0;
            miss_count      <= '0;
            resp_valid      <= 1'b0;
            resp_pc_try     <= '0;
            resp_pc_factual <= '0;
            resp_insn       <= '0;
            resp_miss       <= 1'b0;
        end else begin
            if (accept) begin
                resp_valid      <= 1'b1;
                resp_pc_try     <= req_pc;
                resp_pc_factual <= head_pc;
                resp_insn       <= is_miss ? '0 : head_insn;
                resp_miss       <= is_miss;
            end else if (resp_ready) begin
                resp_valid <= 1'b0;
            end

            // clear and accept never coincide: clear forces req_ready low.
            if (clear) begin
                state      <= ST_RUN;
                consec     <= '0;
                miss_count <= '0;
            end else if (accept) begin
                if (is_miss) begin
                    if (miss_count != {CNT_W{1'b1}}) begin
                        miss_count <= miss_count + 1'b1;
                    end
                    if (MISS_LIMIT != 0) begin
                        consec <= cons_inc;
                        if (cons_inc == LIMIT_V) begin
                            state <= ST_HALT;
                        end
                    end
                end else begin
                    consec <= '0;
                end
            end
        end
    end

endmodule
